// File: rtl/rob_pkg.sv
// Shared ROB parameters, entry/retire-slot types and the retire-slot builder.
package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int IDX_W     = 6;
  localparam int PREG_W    = 6;
  localparam int XLEN      = 32;
  localparam int NUM_CMP   = 3;
  localparam int NUM_RET   = 2;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [XLEN-1:0]   pc;
    logic [4:0]        areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              has_dest;
    logic [XLEN-1:0]   data;
  } rob_entry_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [4:0]        areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              has_dest;
    logic [XLEN-1:0]   data;
  } retire_slot_t;

  // Idle slots are driven to all-zero so downstream never sees stale fields.
  function automatic retire_slot_t make_slot(input logic fire, input rob_entry_t e,
                                             input logic [XLEN-1:0] data);
    retire_slot_t s;
    s = '0;
    if (fire) begin
      s.valid    = 1'b1;
      s.pc       = e.pc;
      s.areg     = e.areg;
      s.preg     = e.preg;
      s.old_preg = e.old_preg;
      s.has_dest = e.has_dest;
      s.data     = data;
    end
    return s;
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail/count bookkeeping; pointers carry a wrap bit above the index.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [1:0]       ret_cnt,
  output logic             alloc_ready,
  output logic             alloc_fire,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W-1:0] head1_idx,
  output logic [IDX_W-1:0] tail_idx,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;
  logic [IDX_W:0] count_q, count_d;
  logic           full;

  // Full uses the pre-retire pointers, so a retiring full ROB still refuses.
  assign full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                       (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && !full;
  assign head_idx    = head_q[IDX_W-1:0];
  assign head1_idx   = head_q[IDX_W-1:0] + IDX_W'(1);
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign count       = count_q;
  assign empty       = (count_q == '0);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      tail_d  = tail_q + (IDX_W+1)'(alloc_fire);
      head_d  = head_q + (IDX_W+1)'(ret_cnt);
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(ret_cnt);
    end
  end

  // NOTE: state flops use non-blocking assignment so all updates land together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, 3-port completion, 2-wide in-order retire.
// Define ROB_COMMIT_BYPASS_EN to let same-cycle completions make head entries retire-eligible.
module rob_commit
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_rob,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic [4:0]        alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  input  logic              alloc_has_dest,
  input  logic              cmp0_valid,
  input  logic [IDX_W-1:0]  cmp0_rob,
  input  logic [XLEN-1:0]   cmp0_data,
  input  logic              cmp1_valid,
  input  logic [IDX_W-1:0]  cmp1_rob,
  input  logic [XLEN-1:0]   cmp1_data,
  input  logic              cmp2_valid,
  input  logic [IDX_W-1:0]  cmp2_rob,
  input  logic [XLEN-1:0]   cmp2_data,
  output logic              ret0_valid,
  output logic [XLEN-1:0]   ret0_pc,
  output logic [4:0]        ret0_areg,
  output logic [PREG_W-1:0] ret0_preg,
  output logic [PREG_W-1:0] ret0_old_preg,
  output logic              ret0_has_dest,
  output logic [XLEN-1:0]   ret0_data,
  output logic              ret1_valid,
  output logic [XLEN-1:0]   ret1_pc,
  output logic [4:0]        ret1_areg,
  output logic [PREG_W-1:0] ret1_preg,
  output logic [PREG_W-1:0] ret1_old_preg,
  output logic              ret1_has_dest,
  output logic [XLEN-1:0]   ret1_data,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_empty
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [XLEN-1:0]      pc_mem       [ROB_DEPTH];
  logic [4:0]           areg_mem     [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_mem     [ROB_DEPTH];
  logic [PREG_W-1:0]    old_preg_mem [ROB_DEPTH];
  logic                 has_dest_mem [ROB_DEPTH];
  logic [XLEN-1:0]      data_mem     [ROB_DEPTH];

  logic [NUM_CMP-1:0]   cmp_valid;
  logic [IDX_W-1:0]     cmp_rob  [NUM_CMP];
  logic [XLEN-1:0]      cmp_data [NUM_CMP];
  logic [NUM_CMP-1:0]   cmp_hit;

  logic                 alloc_fire;
  logic [IDX_W-1:0]     head_idx, head1_idx, tail_idx;
  logic [1:0]           ret_cnt;

  rob_entry_t           ent   [NUM_RET];
  logic [IDX_W-1:0]     ret_idx [NUM_RET];
  logic [NUM_RET-1:0]   byp_hit;
  logic [XLEN-1:0]      byp_data [NUM_RET];
  logic [NUM_RET-1:0]   elig;
  logic [NUM_RET-1:0]   fire;
  retire_slot_t         ret_q [NUM_RET];
  retire_slot_t         ret_d [NUM_RET];

  rob_ptr_ctrl u_ptr (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .ret_cnt     (ret_cnt),
    .alloc_ready (alloc_ready),
    .alloc_fire  (alloc_fire),
    .head_idx    (head_idx),
    .head1_idx   (head1_idx),
    .tail_idx    (tail_idx),
    .count       (rob_count),
    .empty       (rob_empty)
  );

  assign alloc_rob = tail_idx;

  always_comb begin
    cmp_valid   = {cmp2_valid, cmp1_valid, cmp0_valid};
    cmp_rob[0]  = cmp0_rob;
    cmp_rob[1]  = cmp1_rob;
    cmp_rob[2]  = cmp2_rob;
    cmp_data[0] = cmp0_data;
    cmp_data[1] = cmp1_data;
    cmp_data[2] = cmp2_data;
    for (int n = 0; n < NUM_CMP; n++) cmp_hit[n] = cmp_valid[n] && valid_q[cmp_rob[n]];
  end

  always_comb begin
    ret_idx[0] = head_idx;
    ret_idx[1] = head1_idx;
    for (int k = 0; k < NUM_RET; k++) begin
      ent[k] = '{valid:    valid_q[ret_idx[k]],
                 done:     done_q[ret_idx[k]],
                 pc:       pc_mem[ret_idx[k]],
                 areg:     areg_mem[ret_idx[k]],
                 preg:     preg_mem[ret_idx[k]],
                 old_preg: old_preg_mem[ret_idx[k]],
                 has_dest: has_dest_mem[ret_idx[k]],
                 data:     data_mem[ret_idx[k]]};
      byp_hit[k]  = 1'b0;
      byp_data[k] = ent[k].data;
`ifdef ROB_COMMIT_BYPASS_EN
      // Descending scan so the lowest-numbered matching port supplies the data.
      for (int n = NUM_CMP - 1; n >= 0; n--) begin
        if (cmp_hit[n] && (cmp_rob[n] == ret_idx[k])) begin
          byp_hit[k]  = 1'b1;
          byp_data[k] = cmp_data[n];
        end
      end
`endif
      elig[k] = ent[k].valid && (ent[k].done || byp_hit[k]);
    end
    fire[0] = elig[0];
    fire[1] = elig[0] && elig[1];
    ret_cnt = fire[1] ? 2'd2 : (fire[0] ? 2'd1 : 2'd0);
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int k = 0; k < NUM_RET; k++) ret_d[k] = '0;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
    end else begin
      for (int n = 0; n < NUM_CMP; n++) if (cmp_hit[n]) done_d[cmp_rob[n]] = 1'b1;
      for (int k = 0; k < NUM_RET; k++) begin
        if (fire[k]) begin
          valid_d[ret_idx[k]] = 1'b0;
          done_d[ret_idx[k]]  = 1'b0;
        end
        ret_d[k] = make_slot(fire[k], ent[k], byp_data[k]);
      end
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int k = 0; k < NUM_RET; k++) ret_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int k = 0; k < NUM_RET; k++) ret_q[k] <= ret_d[k];
    end
  end

  // NOTE: payload arrays carry no reset; valid/done gate every read, so contents never matter until written.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_mem[tail_idx]       <= alloc_pc;
      areg_mem[tail_idx]     <= alloc_areg;
      preg_mem[tail_idx]     <= alloc_preg;
      old_preg_mem[tail_idx] <= alloc_old_preg;
      has_dest_mem[tail_idx] <= alloc_has_dest;
    end
    // Port 0 is written last so it wins a same-tag collision.
    for (int n = NUM_CMP - 1; n >= 0; n--) begin
      if (cmp_hit[n]) data_mem[cmp_rob[n]] <= cmp_data[n];
    end
  end

  assign ret0_valid    = ret_q[0].valid;
  assign ret0_pc       = ret_q[0].pc;
  assign ret0_areg     = ret_q[0].areg;
  assign ret0_preg     = ret_q[0].preg;
  assign ret0_old_preg = ret_q[0].old_preg;
  assign ret0_has_dest = ret_q[0].has_dest;
  assign ret0_data     = ret_q[0].data;
  assign ret1_valid    = ret_q[1].valid;
  assign ret1_pc       = ret_q[1].pc;
  assign ret1_areg     = ret_q[1].areg;
  assign ret1_preg     = ret_q[1].preg;
  assign ret1_old_preg = ret_q[1].old_preg;
  assign ret1_has_dest = ret_q[1].has_dest;
  assign ret1_data     = ret_q[1].data;

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected retires, a negedge monitor pops and compares.
module tb_rob_commit;
  import rob_pkg::*;

  logic              clk, rstn, flush;
  logic              alloc_valid, alloc_ready;
  logic [IDX_W-1:0]  alloc_rob;
  logic [XLEN-1:0]   alloc_pc;
  logic [4:0]        alloc_areg;
  logic [PREG_W-1:0] alloc_preg, alloc_old_preg;
  logic              alloc_has_dest;
  logic              cmp0_valid, cmp1_valid, cmp2_valid;
  logic [IDX_W-1:0]  cmp0_rob, cmp1_rob, cmp2_rob;
  logic [XLEN-1:0]   cmp0_data, cmp1_data, cmp2_data;
  logic              ret0_valid, ret1_valid;
  logic [XLEN-1:0]   ret0_pc, ret1_pc, ret0_data, ret1_data;
  logic [4:0]        ret0_areg, ret1_areg;
  logic [PREG_W-1:0] ret0_preg, ret1_preg, ret0_old_preg, ret1_old_preg;
  logic              ret0_has_dest, ret1_has_dest;
  logic [IDX_W:0]    rob_count;
  logic              rob_empty;

  rob_commit dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .alloc_pc(alloc_pc), .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_has_dest(alloc_has_dest),
    .cmp0_valid(cmp0_valid), .cmp0_rob(cmp0_rob), .cmp0_data(cmp0_data),
    .cmp1_valid(cmp1_valid), .cmp1_rob(cmp1_rob), .cmp1_data(cmp1_data),
    .cmp2_valid(cmp2_valid), .cmp2_rob(cmp2_rob), .cmp2_data(cmp2_data),
    .ret0_valid(ret0_valid), .ret0_pc(ret0_pc), .ret0_areg(ret0_areg),
    .ret0_preg(ret0_preg), .ret0_old_preg(ret0_old_preg),
    .ret0_has_dest(ret0_has_dest), .ret0_data(ret0_data),
    .ret1_valid(ret1_valid), .ret1_pc(ret1_pc), .ret1_areg(ret1_areg),
    .ret1_preg(ret1_preg), .ret1_old_preg(ret1_old_preg),
    .ret1_has_dest(ret1_has_dest), .ret1_data(ret1_data),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                slot;  // 0 or 1 required slot, 2 = either
    logic [XLEN-1:0]   pc;
    logic [4:0]        areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              has_dest;
    logic [XLEN-1:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq_of_tag[ROB_DEPTH];
  int   tb_tail  = 0;
  int   next_seq = 0;

  // Per-instruction field patterns, all derived from the program-order sequence number.
  function automatic logic [XLEN-1:0]   f_pc(int s);   return 32'h0000_1000 + 32'(s * 4); endfunction
  function automatic logic [4:0]        f_areg(int s); return 5'(s); endfunction
  function automatic logic [PREG_W-1:0] f_preg(int s); return 6'((s + 7) % 64); endfunction
  function automatic logic [PREG_W-1:0] f_old(int s);  return 6'((s * 3) % 64); endfunction
  function automatic logic              f_hd(int s);   return (s % 3) != 0; endfunction
  function automatic logic [XLEN-1:0]   f_data(int s); return 32'hD000_0000 + 32'(s); endfunction
  function automatic logic [XLEN-1:0]   dat(int t);    return f_data(seq_of_tag[t]); endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int s, input logic [XLEN-1:0] d, input int slot);
    exp_t e;
    e.slot = slot; e.pc = f_pc(s); e.areg = f_areg(s); e.preg = f_preg(s);
    e.old_preg = f_old(s); e.has_dest = f_hd(s); e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_slot(input int k, input logic [XLEN-1:0] pc, input logic [4:0] areg,
                          input logic [PREG_W-1:0] preg, input logic [PREG_W-1:0] old_preg,
                          input logic hd, input logic [XLEN-1:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_retire slot%0d: got pc 0x%0h, expected no retire (t=%0t)", k, pc, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.slot != 2) check("ret_slot", 64'(k), 64'(e.slot));
      check("ret_pc", pc, e.pc);
      check("ret_areg", areg, e.areg);
      check("ret_preg", preg, e.preg);
      check("ret_old_preg", old_preg, e.old_preg);
      check("ret_has_dest", hd, e.has_dest);
      check("ret_data", d, e.data);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (ret1_valid) check("ret1_implies_ret0", ret0_valid, 1);
        if (ret0_valid) mon_slot(0, ret0_pc, ret0_areg, ret0_preg, ret0_old_preg, ret0_has_dest, ret0_data);
        if (ret1_valid) mon_slot(1, ret1_pc, ret1_areg, ret1_preg, ret1_old_preg, ret1_has_dest, ret1_data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_alloc_fields(input int s);
    alloc_pc = f_pc(s); alloc_areg = f_areg(s); alloc_preg = f_preg(s);
    alloc_old_preg = f_old(s); alloc_has_dest = f_hd(s);
  endtask

  task automatic alloc_one();
    check("alloc_rob", alloc_rob, 64'(tb_tail % ROB_DEPTH));
    check("alloc_ready", alloc_ready, 1);
    drive_alloc_fields(next_seq);
    seq_of_tag[tb_tail % ROB_DEPTH] = next_seq;
    alloc_valid = 1'b1;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
    tb_tail++;
    next_seq++;
  endtask

  task automatic cmp_cycle(input bit v0, input int t0, input logic [XLEN-1:0] d0,
                           input bit v1, input int t1, input logic [XLEN-1:0] d1,
                           input bit v2, input int t2, input logic [XLEN-1:0] d2);
    cmp0_valid = v0; cmp0_rob = IDX_W'(t0); cmp0_data = d0;
    cmp1_valid = v1; cmp1_rob = IDX_W'(t1); cmp1_data = d1;
    cmp2_valid = v2; cmp2_rob = IDX_W'(t2); cmp2_data = d2;
    @(posedge clk); #1;
    cmp0_valid = 1'b0; cmp1_valid = 1'b0; cmp2_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rstn = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
    drive_alloc_fields(0);
    cmp0_valid = 1'b0; cmp1_valid = 1'b0; cmp2_valid = 1'b0;
    cmp0_rob = '0; cmp1_rob = '0; cmp2_rob = '0;
    cmp0_data = '0; cmp1_data = '0; cmp2_data = '0;

    // Reset state
    #12;
    check("reset_count", rob_count, 0);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_empty", rob_empty, 1);
    check("reset_ret0_valid", ret0_valid, 0);
    check("reset_ret1_valid", ret1_valid, 0);
    check("reset_alloc_rob", alloc_rob, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // In-order retire: complete 2, 1, then 0
    repeat (3) alloc_one();
    check("inorder_count3", rob_count, 3);
    cmp_cycle(1, 2, dat(2), 0, 0, 0, 0, 0, 0);
    cmp_cycle(0, 0, 0, 1, 1, dat(1), 0, 0, 0);
    idle(2);
    check("inorder_no_retire_count", rob_count, 3);
    check("inorder_not_empty", rob_empty, 0);
    push_exp(seq_of_tag[0], dat(0), 0);
    push_exp(seq_of_tag[1], dat(1), 1);
    push_exp(seq_of_tag[2], dat(2), 0);
    cmp_cycle(0, 0, 0, 0, 0, 0, 1, 0, dat(0));
    idle(4);
    check("inorder_drained", rob_count, 0);
    check("inorder_empty", rob_empty, 1);

    // Port collision on tag 5: port 0 must win
    repeat (3) alloc_one();
    push_exp(seq_of_tag[3], dat(3), 0);
    push_exp(seq_of_tag[4], dat(4), 0);
    push_exp(seq_of_tag[5], 32'hAAAA_0000, 1);
    cmp_cycle(1, 5, 32'hAAAA_0000, 1, 3, dat(3), 1, 5, 32'hBBBB_0000);
    cmp_cycle(1, 4, dat(4), 0, 0, 0, 0, 0, 0);
    idle(4);
    check("collision_drained", rob_count, 0);

    // Full: 64 entries, head and tail both at index 6
    repeat (ROB_DEPTH) alloc_one();
    check("full_count", rob_count, 64);
    check("full_alloc_ready", alloc_ready, 0);
    check("full_alloc_rob", alloc_rob, 6);
    drive_alloc_fields(999);
    alloc_valid = 1'b1;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
    check("full_refused_count", rob_count, 64);
    check("full_refused_alloc_rob", alloc_rob, 6);
    push_exp(seq_of_tag[6], dat(6), 0);
    cmp_cycle(1, 6, dat(6), 0, 0, 0, 0, 0, 0);
    idle(3);
    check("after_full_count", rob_count, 63);
    check("after_full_alloc_ready", alloc_ready, 1);
    check("after_full_alloc_rob", alloc_rob, 6);

    // Bulk drain of tags 7..62, then a retire pair straddling the wrap (63, 0)
    for (int t = 7; t <= 62; t++) push_exp(seq_of_tag[t], dat(t), 2);
    for (int t = 7; t <= 62; t += 3)
      cmp_cycle(1, t, dat(t), t + 1 <= 62, t + 1, dat(t + 1), t + 2 <= 62, t + 2, dat(t + 2));
    idle(40);
    check("bulk_count", rob_count, 7);
    push_exp(seq_of_tag[63], dat(63), 0);
    push_exp(seq_of_tag[0], dat(0), 1);
    cmp_cycle(1, 63, dat(63), 1, 0, dat(0), 0, 0, 0);
    idle(3);
    check("wrap_pair_count", rob_count, 5);

    // Flush with 10 entries, two done, plus same-cycle alloc and completion
    repeat (5) alloc_one();
    check("preflush_count", rob_count, 10);
    cmp_cycle(1, 3, dat(3), 1, 4, dat(4), 0, 0, 0);
    flush = 1'b1;
    alloc_valid = 1'b1;
    drive_alloc_fields(next_seq);
    cmp0_valid = 1'b1; cmp0_rob = IDX_W'(1); cmp0_data = 32'h1234_5678;
    @(posedge clk); #1;
    flush = 1'b0; alloc_valid = 1'b0; cmp0_valid = 1'b0;
    tb_tail = 0;
    check("flush_count", rob_count, 0);
    check("flush_alloc_rob", alloc_rob, 0);
    check("flush_empty", rob_empty, 1);
    check("flush_alloc_ready", alloc_ready, 1);
    check("flush_ret0_valid", ret0_valid, 0);
    check("flush_ret1_valid", ret1_valid, 0);
    cmp_cycle(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("stale_cmp_count", rob_count, 0);

    // Asynchronous reset while a retire is being presented
    repeat (3) alloc_one();
    push_exp(seq_of_tag[0], dat(0), 0);
    push_exp(seq_of_tag[1], dat(1), 1);
    cmp_cycle(1, 0, dat(0), 1, 1, dat(1), 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      found = ret0_valid;
    end
    check("retire_seen_before_reset", found, 1);
    #1 rstn = 1'b0;
    #1;
    check("midreset_count", rob_count, 0);
    check("midreset_alloc_ready", alloc_ready, 1);
    check("midreset_empty", rob_empty, 1);
    check("midreset_ret0_valid", ret0_valid, 0);
    check("midreset_ret1_valid", ret1_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(3);
    check("postreset_count", rob_count, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
